// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency-counter gate controller.
// States are plain logic constants so older code can compare against them directly.
package freq_pkg;

  localparam int unsigned DEF_WIN_W      = 10;
  localparam int unsigned DEF_MEAS_W     = 16;
  localparam int unsigned DEF_SETTLE_CYC = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_GATE   = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_LATCH  = 3'd4;

endpackage

// File: rtl/gate_dn_counter.sv
// Loadable down-counter with zero flag; times both the gate window and the settle gap.
module gate_dn_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement-window controller: clear, gate and latch strobes for the frequency counter.
// Define GATE_ABORT_EN to add an abort input that cancels an in-flight window.
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned WIN_W      = DEF_WIN_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned MEAS_W     = DEF_MEAS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [WIN_W-1:0]  win_len,
`ifdef GATE_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              clr_pulse,
  output logic              enable,
  output logic              latch_pulse,
  output logic              done,
  output logic [MEAS_W-1:0] meas_cnt
);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]   win_nz;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [WIN_W-1:0]   cnt_val;

  // A zero-length request still opens the gate for one cycle.
  assign win_nz = (win_len == '0) ? WIN_W'(1) : win_len;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = win_q - WIN_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d   = win_nz;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_load = 1'b1;
        state_d  = ST_GATE;
      end
      ST_GATE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = WIN_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_LATCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LATCH: begin
        if (continuous) begin
          win_d   = win_nz;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef GATE_ABORT_EN
    if (abort && ((state_q == ST_CLEAR) || (state_q == ST_GATE) || (state_q == ST_SETTLE))) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
`endif
  end

  gate_dn_counter #(
    .W (WIN_W)
  ) u_dn_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      busy        <= 1'b0;
      clr_pulse   <= 1'b0;
      enable      <= 1'b0;
      latch_pulse <= 1'b0;
      done        <= 1'b0;
      meas_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      busy        <= (state_d != ST_IDLE);
      clr_pulse   <= (state_d == ST_CLEAR);
      enable      <= (state_d == ST_GATE);
      latch_pulse <= (state_d == ST_LATCH);
      done        <= (state_d == ST_LATCH);
      if (state_d == ST_LATCH) begin
        meas_cnt <= meas_cnt + MEAS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: vector table plus multi-cycle corner sequences.
// Builds with or without GATE_ABORT_EN.
module tb_freq_gate_ctrl;

  localparam int unsigned WIN_W  = 10;
  localparam int unsigned MEAS_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [WIN_W-1:0]  win_len = '0;
`ifdef GATE_ABORT_EN
  logic              abort = 1'b0;
`endif
  logic              busy, clr_pulse, enable, latch_pulse, done;
  logic [MEAS_W-1:0] meas_cnt;

  freq_gate_ctrl #(
    .WIN_W      (WIN_W),
    .SETTLE_CYC (3),
    .MEAS_W     (MEAS_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .win_len     (win_len),
`ifdef GATE_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .clr_pulse   (clr_pulse),
    .enable      (enable),
    .latch_pulse (latch_pulse),
    .done        (done),
    .meas_cnt    (meas_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // flags = {busy, clr_pulse, enable, latch_pulse, done}
  typedef struct {
    logic              start;
    logic [WIN_W-1:0]  win;
    logic [4:0]        flags;
    logic [MEAS_W-1:0] meas;
  } vec_t;

  vec_t tbl[18];

  logic [31:0] en_m, clr_m, done_m, latch_m, busy_m;
  int          done_cnt, done_cyc;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // win_len=5 single shot; win_len change and start re-pulse mid-gate must be ignored
    tbl[0]  = '{1'b1, 10'd5, 5'b11000, 16'd0};
    tbl[1]  = '{1'b0, 10'd5, 5'b10100, 16'd0};
    tbl[2]  = '{1'b0, 10'd9, 5'b10100, 16'd0};
    tbl[3]  = '{1'b1, 10'd9, 5'b10100, 16'd0};
    tbl[4]  = '{1'b0, 10'd9, 5'b10100, 16'd0};
    tbl[5]  = '{1'b0, 10'd9, 5'b10100, 16'd0};
    tbl[6]  = '{1'b0, 10'd9, 5'b10000, 16'd0};
    tbl[7]  = '{1'b0, 10'd9, 5'b10000, 16'd0};
    tbl[8]  = '{1'b0, 10'd9, 5'b10000, 16'd0};
    tbl[9]  = '{1'b0, 10'd9, 5'b10011, 16'd1};
    tbl[10] = '{1'b0, 10'd9, 5'b00000, 16'd1};
    // win_len=0 behaves as a one-cycle window
    tbl[11] = '{1'b1, 10'd0, 5'b11000, 16'd1};
    tbl[12] = '{1'b0, 10'd0, 5'b10100, 16'd1};
    tbl[13] = '{1'b0, 10'd0, 5'b10000, 16'd1};
    tbl[14] = '{1'b0, 10'd0, 5'b10000, 16'd1};
    tbl[15] = '{1'b0, 10'd0, 5'b10000, 16'd1};
    tbl[16] = '{1'b0, 10'd0, 5'b10011, 16'd2};
    tbl[17] = '{1'b0, 10'd0, 5'b00000, 16'd2};

    #1;
    check("reset_flags", {27'd0, busy, clr_pulse, enable, latch_pulse, done}, 32'd0);
    check("reset_meas", 32'(meas_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      start   = tbl[i].start;
      win_len = tbl[i].win;
      @(negedge clk);
      check($sformatf("vec%0d_flags", i),
            {27'd0, busy, clr_pulse, enable, latch_pulse, done}, {27'd0, tbl[i].flags});
      check($sformatf("vec%0d_meas", i), 32'(meas_cnt), 32'(tbl[i].meas));
    end
    start = 1'b0;

    // Continuous: 4-cycle window, then 7-cycle window with no IDLE gap
    do_reset();
    en_m = '0; clr_m = '0; done_m = '0; latch_m = '0; busy_m = '0;
    continuous = 1'b1;
    win_len    = 10'd4;
    start      = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      en_m[c]    = enable;
      clr_m[c]   = clr_pulse;
      done_m[c]  = done;
      latch_m[c] = latch_pulse;
      busy_m[c]  = busy;
      start = 1'b0;
      if (c == 3)  win_len = 10'd7;
      if (c == 12) continuous = 1'b0;
    end
    check("cont_enable", en_m, 32'h0003_F83C);
    check("cont_clr", clr_m, 32'h0000_0402);
    check("cont_done", done_m, 32'h0020_0200);
    check("cont_latch", latch_m, 32'h0020_0200);
    check("cont_busy", busy_m, 32'h003F_FFFE);
    check("cont_meas", 32'(meas_cnt), 32'd2);

    // Async reset in the middle of the gate
    do_reset();
    win_len = 10'd5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_enable", {31'd0, enable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_flags", {27'd0, busy, clr_pulse, enable, latch_pulse, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_meas", 32'(meas_cnt), 32'd0);
    win_len  = 10'd2;
    start    = 1'b1;
    done_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done && done_cyc == 0) done_cyc = c;
    end
    check("post_rst_done_cyc", 32'(done_cyc), 32'd7);
    check("post_rst_meas", 32'(meas_cnt), 32'd1);

`ifdef GATE_ABORT_EN
    // Abort in the third gate cycle of a 10-cycle window
    do_reset();
    en_m = '0; done_m = '0; busy_m = '0;
    win_len = 10'd10;
    start   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      en_m[c]   = enable;
      done_m[c] = done;
      busy_m[c] = busy;
      start = 1'b0;
      abort = (c == 4);
    end
    abort = 1'b0;
    check("abort_enable", en_m, 32'h0000_001C);
    check("abort_busy", busy_m, 32'h0000_001E);
    check("abort_done", done_m, 32'd0);
    check("abort_meas", 32'(meas_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
